// File: rtl/mux2_1_if.sv
// Port bundle for mux2_1: two data sources, a select, the selected data and the clocked status.
// The master drives sel/a/b; the slave (the mux) returns y, valid and switch_cnt.
interface mux2_1_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             valid;
  logic [CNT_W-1:0] switch_cnt;

  modport master (output sel, a, b, input y, valid, switch_cnt);
  modport slave  (input sel, a, b, output y, valid, switch_cnt);
endinterface

// File: rtl/mux2_1.sv
// 2:1 data mux with a saturating select-transition counter and a post-reset valid flag.
// Define MUX2_1_REG_OUT_EN to register y; by default y is purely combinational.
module mux2_1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  mux2_1_if.slave  bus
);

  logic [WIDTH-1:0] mux_d;
  logic             sel_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  // An if/else (not ?:) so that an unknown select resolves to b instead of merging a and b.
  always_comb begin
    mux_d = bus.b;
    if (bus.sel == 1'b0) begin
      mux_d = bus.a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sel_q   <= bus.sel;
      valid_q <= 1'b1;
      if ((bus.sel != sel_q) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef MUX2_1_REG_OUT_EN
  logic [WIDTH-1:0] y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= mux_d;
    end
  end

  assign bus.y = y_q;
`else
  assign bus.y = mux_d;
`endif

  assign bus.valid      = valid_q;
  assign bus.switch_cnt = cnt_q;

endmodule

// File: tb/tb_mux2_1.sv
// Directed bench for mux2_1: an 8-bit/2-bit-counter instance and a 1-bit/8-bit-counter instance
// share the same select; expected outputs are queued at drive time and popped after the edge.
`timescale 1ns/1ps
module tb_mux2_1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux2_1_if #(.WIDTH(8), .CNT_W(2)) bus8 ();
  mux2_1_if #(.WIDTH(1), .CNT_W(8)) bus1 ();

  assign bus1.sel = bus8.sel;
  assign bus1.a   = bus8.a[0];
  assign bus1.b   = bus8.b[0];

  mux2_1 #(.WIDTH(8), .CNT_W(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  mux2_1 #(.WIDTH(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct packed {
    logic [7:0] y8;
    logic       y1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       sel_m;
  logic [1:0] cnt8_m;
  logic [7:0] cnt1_m;
  logic       valid_m;
  logic [7:0] yreg_m;

  function automatic logic [7:0] mux_f(input logic s, input logic [7:0] a, input logic [7:0] b);
    return (s === 1'b0) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic [7:0] m);
    if (s != sel_m) begin
      if (cnt8_m != 2'b11) cnt8_m++;
      if (cnt1_m != 8'hFF) cnt1_m++;
    end
    sel_m   = s;
    valid_m = 1'b1;
    yreg_m  = m;
  endtask

  task automatic post_edge(input string tag, input bit chk_cnt);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_y8"}, {24'd0, bus8.y}, {24'd0, e.y8});
      check({tag, "_y1"}, {31'd0, bus1.y}, {31'd0, e.y1});
    end
    check({tag, "_valid"}, {31'd0, bus8.valid}, {31'd0, valid_m});
    check({tag, "_valid1"}, {31'd0, bus1.valid}, {31'd0, valid_m});
    if (chk_cnt) begin
      check({tag, "_cnt8"}, {30'd0, bus8.switch_cnt}, {30'd0, cnt8_m});
      check({tag, "_cnt1"}, {24'd0, bus1.switch_cnt}, {24'd0, cnt1_m});
    end
  endtask

  task automatic step(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input bit chk_cnt);
    logic [7:0] m;
    @(negedge clk);
    bus8.sel = s;
    bus8.a   = a;
    bus8.b   = b;
    m = mux_f(s, a, b);
    sb.push_back('{y8: m, y1: m[0]});
    #2;
`ifdef MUX2_1_REG_OUT_EN
    check({tag, "_hold"}, {24'd0, bus8.y}, {24'd0, yreg_m});
`else
    check({tag, "_comb"}, {24'd0, bus8.y}, {24'd0, m});
`endif
    @(posedge clk);
    model_edge(s, m);
    post_edge(tag, chk_cnt);
  endtask

  // Select pulses away and back inside one cycle; the counter must not see it.
  task automatic glitch(input string tag);
    logic [7:0] m;
    @(negedge clk);
    bus8.sel = ~sel_m;
    #2;
    bus8.sel = sel_m;
    m = mux_f(sel_m, bus8.a, bus8.b);
    sb.push_back('{y8: m, y1: m[0]});
    @(posedge clk);
    model_edge(sel_m, m);
    post_edge(tag, 1'b1);
  endtask

  task automatic mid_reset();
    logic [7:0] m;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sel_m = 1'b0; cnt8_m = '0; cnt1_m = '0; valid_m = 1'b0; yreg_m = '0;
    m = mux_f(bus8.sel, bus8.a, bus8.b);
    check("rst_valid", {31'd0, bus8.valid}, 32'd0);
    check("rst_cnt8", {30'd0, bus8.switch_cnt}, 32'd0);
    check("rst_cnt1", {24'd0, bus1.switch_cnt}, 32'd0);
`ifdef MUX2_1_REG_OUT_EN
    check("rst_y8", {24'd0, bus8.y}, 32'd0);
`else
    check("rst_y8", {24'd0, bus8.y}, {24'd0, m});
`endif
    @(posedge clk);
    #1;
    check("rst_hold_valid", {31'd0, bus8.valid}, 32'd0);
    check("rst_hold_cnt8", {30'd0, bus8.switch_cnt}, 32'd0);
    @(negedge clk);
    bus8.sel = 1'b1;
    bus8.a   = 8'h5A;
    bus8.b   = 8'hC3;
    rst      = 1'b0;
    m = mux_f(1'b1, 8'h5A, 8'hC3);
    sb.push_back('{y8: m, y1: m[0]});
    @(posedge clk);
    model_edge(1'b1, m);
    post_edge("after_rst", 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    bus8.sel = 1'b0;
    bus8.a   = 8'hA5;
    bus8.b   = 8'h3C;
    sel_m = 1'b0; cnt8_m = '0; cnt1_m = '0; valid_m = 1'b0; yreg_m = '0;
    #2;
    check("init_valid", {31'd0, bus8.valid}, 32'd0);
    check("init_cnt8", {30'd0, bus8.switch_cnt}, 32'd0);
    check("init_cnt1", {24'd0, bus1.switch_cnt}, 32'd0);
`ifdef MUX2_1_REG_OUT_EN
    check("init_y8", {24'd0, bus8.y}, 32'd0);
    check("init_y1", {31'd0, bus1.y}, 32'd0);
`else
    check("init_y8", {24'd0, bus8.y}, 32'hA5);
    check("init_y1", {31'd0, bus1.y}, 32'd1);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("s0_a",   1'b0, 8'hA5, 8'h3C, 1'b1);
    step("s1_b",   1'b1, 8'hA5, 8'h3C, 1'b1);
    step("s2_a",   1'b0, 8'hA5, 8'h3C, 1'b1);
    step("sat_3",  1'b1, 8'hA5, 8'h3C, 1'b1);
    step("sat_4",  1'b0, 8'hA5, 8'h3C, 1'b1);
    step("sat_5",  1'b1, 8'hA5, 8'h3C, 1'b1);
    step("sat_6",  1'b0, 8'hA5, 8'h3C, 1'b1);
    step("simul1", 1'b1, 8'h11, 8'h22, 1'b1);
    step("simul2", 1'b0, 8'h33, 8'h44, 1'b1);
    glitch("glitch");
    step("hold_b", 1'b1, 8'h00, 8'hFF, 1'b1);
    step("hold_b2", 1'b1, 8'h0F, 8'hF0, 1'b1);
    step("sel_x",  1'bx, 8'h00, 8'hFF, 1'b0);

    mid_reset();
    step("post1", 1'b1, 8'h77, 8'h88, 1'b1);
    step("post2", 1'b0, 8'h77, 8'h88, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
